// File: rtl/dds_pkg.sv
// Shared types for the DDS tune scheduler: command encodings, FSM states and
// the accumulator width helper that must track the DDS core geometry.
package dds_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_TUNE = 2'b01,
        CMD_ACC  = 2'b10,
        CMD_BOTH = 2'b11
    } cmd_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_FIRE  = 2'b10
    } state_e;

    function automatic int f_acc_bits(input int frac_bits, input int lut_size_log2);
        return frac_bits + lut_size_log2 + 1;
    endfunction

endpackage

// File: rtl/dds_cmd_fifo.sv
// Synchronous command FIFO with first-word-fall-through head, occupancy count
// and a synchronous flush that overrides any push or pop in the same cycle.
module dds_cmd_fifo #(
    parameter int g_width      = 8,
    parameter int g_depth_log2 = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [g_width-1:0]      data_i,
    output logic [g_width-1:0]      head_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [g_depth_log2:0]   count_o
);

    localparam int c_depth = 1 << g_depth_log2;

    logic [g_width-1:0]      mem [c_depth];
    logic [g_depth_log2-1:0] wr_ptr;
    logic [g_depth_log2-1:0] rd_ptr;
    logic [g_depth_log2:0]   count;
    logic                    do_push;
    logic                    do_pop;

    assign empty_o = (count == '0);
    // Occupancy can never exceed the depth, so its top bit alone means full.
    assign full_o  = count[g_depth_log2];
    assign count_o = count;
    assign head_o  = mem[rd_ptr];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + g_depth_log2'(1);
            if (do_pop)  rd_ptr <= rd_ptr + g_depth_log2'(1);
            count <= count + {{g_depth_log2{1'b0}}, do_push} - {{g_depth_log2{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/dds_tune_scheduler.sv
// Timestamped tune/phase command scheduler: queues commands and releases their
// DDS load pulses when the sample-tick counter reaches each command's timestamp.
module dds_tune_scheduler
    import dds_pkg::*;
#(
    parameter  int g_acc_frac_bits   = 32,
    parameter  int g_lut_size_log2   = 10,
    parameter  int g_fifo_depth_log2 = 2,
    parameter  int g_time_bits       = 32,
    localparam int c_acc_bits        = f_acc_bits(g_acc_frac_bits, g_lut_size_log2)
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         dreq_i,
    input  logic                         cnt_load_i,
    input  logic [g_time_bits-1:0]       cnt_val_i,
    input  logic                         flush_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [1:0]                   cmd_type_i,
    input  logic                         cmd_imm_i,
    input  logic [g_time_bits-1:0]       cmd_time_i,
    input  logic [c_acc_bits-1:0]        cmd_tune_i,
    input  logic [c_acc_bits-1:0]        cmd_acc_i,
    output logic [c_acc_bits-1:0]        tune_o,
    output logic                         tune_load_o,
    output logic [c_acc_bits-1:0]        acc_o,
    output logic                         acc_load_o,
    output logic                         late_o,
    output logic                         busy_o,
    output logic [g_fifo_depth_log2:0]   fifo_count_o,
    output logic [g_time_bits-1:0]       tick_cnt_o
);

    localparam int c_cmd_w = 3 + g_time_bits + 2 * c_acc_bits;

    logic [g_time_bits-1:0]        tick_cnt;
    logic                          ready_en;
    logic                          fifo_empty;
    logic                          fifo_full;
    logic                          push;
    logic                          pop;
    logic                          fire;
    logic [c_cmd_w-1:0]            cmd_in;
    logic [c_cmd_w-1:0]            head;
    state_e                        state_q;
    state_e                        state_d;
    cmd_type_e                     cur_type;
    logic                          cur_imm;
    logic [g_time_bits-1:0]        cur_time;
    logic [c_acc_bits-1:0]         cur_tune;
    logic [c_acc_bits-1:0]         cur_acc;
    logic signed [g_time_bits-1:0] diff;
    logic                          due;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)        tick_cnt <= '0;
        else if (cnt_load_i) tick_cnt <= cnt_val_i;
        else if (dreq_i)     tick_cnt <= tick_cnt + g_time_bits'(1);
    end

    // Holds ready low until the first clock edge after reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    assign cmd_ready_o  = ready_en & ~fifo_full;
    assign push         = cmd_valid_i & cmd_ready_o & ~flush_i;
    assign cmd_in       = {cmd_type_i, cmd_imm_i, cmd_time_i, cmd_tune_i, cmd_acc_i};
    assign busy_o       = ~fifo_empty | (state_q != ST_IDLE);
    assign tick_cnt_o   = tick_cnt;

    dds_cmd_fifo #(
        .g_width      (c_cmd_w),
        .g_depth_log2 (g_fifo_depth_log2)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (cmd_in),
        .head_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count_o)
    );

    always_ff @(posedge clk_i) begin
        if (pop) begin
            cur_type <= cmd_type_e'(head[c_cmd_w-1 -: 2]);
            cur_imm  <= head[c_cmd_w-3];
            cur_time <= head[2*c_acc_bits +: g_time_bits];
            cur_tune <= head[c_acc_bits +: c_acc_bits];
            cur_acc  <= head[0 +: c_acc_bits];
        end
    end

    // Modular difference: a target just past a counter wrap still reads as future.
    assign diff = $signed(cur_time - tick_cnt);
    assign due  = cur_imm | diff[g_time_bits-1] | (diff == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        fire    = 1'b0;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (!fifo_empty) begin
                              pop     = 1'b1;
                              state_d = ST_ARMED;
                          end
                ST_ARMED: if (due) begin
                              fire    = 1'b1;
                              state_d = ST_FIRE;
                          end
                ST_FIRE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Output stage: pulses are registered on entry to FIRE so they coincide with it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tune_o      <= '0;
            acc_o       <= '0;
            tune_load_o <= 1'b0;
            acc_load_o  <= 1'b0;
            late_o      <= 1'b0;
        end else begin
            tune_load_o <= fire & cur_type[0];
            acc_load_o  <= fire & cur_type[1];
            late_o      <= fire & ~cur_imm & diff[g_time_bits-1] & (cur_type != CMD_NOP);
            if (fire && cur_type[0]) tune_o <= cur_tune;
            if (fire && cur_type[1]) acc_o  <= cur_acc;
        end
    end

endmodule

// File: tb/tb_dds_tune_scheduler.sv
// Directed scoreboard bench for dds_tune_scheduler: stimulus queues expected
// load events, a negedge monitor pops and compares each one the DUT emits.
module tb_dds_tune_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dreq = 1'b1;
    logic        cnt_load = 1'b0;
    logic [31:0] cnt_val = '0;
    logic        flush = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = '0;
    logic        cmd_imm = 1'b0;
    logic [31:0] cmd_time = '0;
    logic [42:0] cmd_tune = '0;
    logic [42:0] cmd_acc = '0;
    logic [42:0] tune;
    logic        tune_load;
    logic [42:0] acc;
    logic        acc_load;
    logic        late;
    logic        busy;
    logic [2:0]  fifo_count;
    logic [31:0] tick_cnt;

    typedef struct {
        logic        tl;
        logic        al;
        logic        late;
        logic [42:0] tune;
        logic [42:0] acc;
        bit          chk_tick;
        logic [31:0] tick;
        bit          chk_cyc;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   mon_ok;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    dds_tune_scheduler dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .dreq_i       (dreq),
        .cnt_load_i   (cnt_load),
        .cnt_val_i    (cnt_val),
        .flush_i      (flush),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_type_i   (cmd_type),
        .cmd_imm_i    (cmd_imm),
        .cmd_time_i   (cmd_time),
        .cmd_tune_i   (cmd_tune),
        .cmd_acc_i    (cmd_acc),
        .tune_o       (tune),
        .tune_load_o  (tune_load),
        .acc_o        (acc),
        .acc_load_o   (acc_load),
        .late_o       (late),
        .busy_o       (busy),
        .fifo_count_o (fifo_count),
        .tick_cnt_o   (tick_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && (tune_load || acc_load || late)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: tl=%0b al=%0b late=%0b tune=%h acc=%h tick=%h, required no event",
                         tune_load, acc_load, late, tune, acc, tick_cnt);
            end else begin
                mon_e  = sb.pop_front();
                mon_ok = (tune_load === mon_e.tl) && (acc_load === mon_e.al) && (late === mon_e.late) &&
                         (tune === mon_e.tune) && (acc === mon_e.acc) &&
                         (!mon_e.chk_tick || tick_cnt === mon_e.tick) &&
                         (!mon_e.chk_cyc || cyc == mon_e.cyc);
                if (!mon_ok) begin
                    errors++;
                    $display("FAIL load_event: got tl=%0b al=%0b late=%0b tune=%h acc=%h tick=%h cyc=%0d, required tl=%0b al=%0b late=%0b tune=%h acc=%h tick=%h(chk %0b) cyc=%0d(chk %0b)",
                             tune_load, acc_load, late, tune, acc, tick_cnt, cyc,
                             mon_e.tl, mon_e.al, mon_e.late, mon_e.tune, mon_e.acc,
                             mon_e.tick, mon_e.chk_tick, mon_e.cyc, mon_e.chk_cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cnt(input logic [31:0] v);
        cnt_load = 1'b1;
        cnt_val  = v;
        tick();
        cnt_load = 1'b0;
    endtask

    // Issues one command and, when it should fire, queues the expected event.
    // A due command pulses two edges after the accepting edge (third cycle counting the push cycle).
    task automatic push(input logic [1:0] ty, input logic imm, input logic [31:0] t,
                        input logic [42:0] tu, input logic [42:0] ac,
                        input bit exp_fire, input logic exp_late,
                        input logic [42:0] exp_tune, input logic [42:0] exp_acc,
                        input bit chk_tick, input logic [31:0] exp_tick, input bit chk_cyc);
        exp_t e;
        int   n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL push_ready_timeout: got ready=0, required ready=1");
            return;
        end
        cmd_valid = 1'b1;
        cmd_type  = ty;
        cmd_imm   = imm;
        cmd_time  = t;
        cmd_tune  = tu;
        cmd_acc   = ac;
        tick();
        cmd_valid = 1'b0;
        if (exp_fire) begin
            e.tl       = ty[0];
            e.al       = ty[1];
            e.late     = exp_late;
            e.tune     = exp_tune;
            e.acc      = exp_acc;
            e.chk_tick = chk_tick;
            e.tick     = exp_tick;
            e.chk_cyc  = chk_cyc;
            e.cyc      = cyc + 2;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(sb.size()), 64'(0));
    endtask

    initial begin
        // Reset state, including ready held low while reset is asserted across edges.
        #2;
        check("rst_ready",  64'(cmd_ready),  64'(0));
        check("rst_tune",   64'(tune),       64'(0));
        check("rst_count",  64'(fifo_count), 64'(0));
        check("rst_busy",   64'(busy),       64'(0));
        repeat (3) tick();
        check("rst_ready_held", 64'(cmd_ready), 64'(0));
        check("rst_tick",   64'(tick_cnt),   64'(0));
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", 64'(cmd_ready), 64'(1));

        // 1: timed TUNE, pulse while counter reads target+1.
        push(2'b01, 1'b0, 32'd100, 43'h100, 43'h0, 1, 1'b0, 43'h100, 43'h0, 1, 32'd101, 0);
        wait_drain("drain_t1", 300);

        // 2: immediate BOTH with a stale timestamp must not report late; NOP is silent.
        push(2'b11, 1'b1, 32'd0, 43'h5, 43'h7, 1, 1'b0, 43'h5, 43'h7, 0, 32'd0, 1);
        wait_drain("drain_t2", 50);
        push(2'b00, 1'b0, 32'd0, 43'h1FF, 43'h1FF, 0, 1'b0, 43'h0, 43'h0, 0, 32'd0, 0);
        wait_drain("drain_nop", 50);

        // 3: past-due ACC fires at minimum latency and flags late.
        load_cnt(32'd500);
        push(2'b10, 1'b0, 32'd400, 43'h0, 43'hABC, 1, 1'b1, 43'h5, 43'hABC, 0, 32'd0, 1);
        wait_drain("drain_t3", 50);

        // 4: five back-to-back, first held in ARMED so four fill the FIFO.
        load_cnt(32'd1000);
        push(2'b01, 1'b0, 32'd1100, 43'h11, 43'h0,  1, 1'b0, 43'h11, 43'hABC, 1, 32'd1101, 0);
        push(2'b01, 1'b0, 32'd1110, 43'h22, 43'h0,  1, 1'b0, 43'h22, 43'hABC, 1, 32'd1111, 0);
        push(2'b10, 1'b0, 32'd1120, 43'h0,  43'h33, 1, 1'b0, 43'h22, 43'h33,  1, 32'd1121, 0);
        push(2'b11, 1'b0, 32'd1130, 43'h44, 43'h55, 1, 1'b0, 43'h44, 43'h55,  1, 32'd1131, 0);
        push(2'b01, 1'b0, 32'd1140, 43'h66, 43'h0,  1, 1'b0, 43'h66, 43'h55,  1, 32'd1141, 0);
        check("full_count", 64'(fifo_count), 64'(4));
        check("full_ready", 64'(cmd_ready),  64'(0));
        cmd_valid = 1'b1;
        cmd_type  = 2'b01;
        cmd_imm   = 1'b1;
        cmd_tune  = 43'hBAD;
        tick();
        cmd_valid = 1'b0;
        check("full_reject_count", 64'(fifo_count), 64'(4));
        wait_drain("drain_t4", 400);

        // 5: target beyond the counter wrap waits rather than firing late.
        load_cnt(32'hFFFF_FFF0);
        push(2'b01, 1'b0, 32'h10, 43'h77, 43'h0, 1, 1'b0, 43'h77, 43'h55, 1, 32'h11, 0);
        wait_drain("drain_wrap", 100);

        // Counter jump past an armed target fires late on the following cycle.
        load_cnt(32'h100);
        push(2'b01, 1'b0, 32'h2000, 43'h88, 43'h0, 1, 1'b1, 43'h88, 43'h55, 1, 32'h3001, 0);
        repeat (3) tick();
        check("armed_busy", 64'(busy), 64'(1));
        load_cnt(32'h3000);
        wait_drain("drain_jump", 20);

        // 6: flush drops queued work and beats a simultaneous push; reset aborts ARMED.
        load_cnt(32'h100);
        push(2'b01, 1'b0, 32'h1000, 43'h1, 43'h0, 0, 1'b0, 43'h0, 43'h0, 0, 32'd0, 0);
        push(2'b10, 1'b0, 32'h1100, 43'h0, 43'h2, 0, 1'b0, 43'h0, 43'h0, 0, 32'd0, 0);
        push(2'b11, 1'b0, 32'h1200, 43'h3, 43'h3, 0, 1'b0, 43'h0, 43'h0, 0, 32'd0, 0);
        check("queued_count", 64'(fifo_count), 64'(2));
        flush     = 1'b1;
        cmd_valid = 1'b1;
        cmd_type  = 2'b11;
        cmd_imm   = 1'b1;
        cmd_tune  = 43'hDEAD;
        cmd_acc   = 43'hDEAD;
        tick();
        flush     = 1'b0;
        cmd_valid = 1'b0;
        check("flush_count", 64'(fifo_count), 64'(0));
        check("flush_busy",  64'(busy),       64'(0));
        repeat (5) tick();
        check("flush_tune_held", 64'(tune), 64'(43'h88));
        push(2'b01, 1'b0, 32'h5000, 43'h9, 43'h0, 0, 1'b0, 43'h0, 43'h0, 0, 32'd0, 0);
        repeat (2) tick();
        check("pre_rst_busy", 64'(busy), 64'(1));
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_tune",  64'(tune),       64'(0));
        check("arst_acc",   64'(acc),        64'(0));
        check("arst_count", 64'(fifo_count), 64'(0));
        check("arst_busy",  64'(busy),       64'(0));
        check("arst_ready", 64'(cmd_ready),  64'(0));
        check("arst_tick",  64'(tick_cnt),   64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        check("ready_after_arst", 64'(cmd_ready), 64'(1));
        repeat (20) tick();
        check("final_busy", 64'(busy), 64'(0));
        check("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
